// File: rtl/alarm_pkg.sv
// Shared types and default timing constants for the alarm ringing sequencer.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RING,
        SNOOZE
    } ring_state_t;

    localparam int unsigned DEF_SNZ_TICKS  = 60000;
    localparam int unsigned DEF_STOP_TICKS = 1000;
    localparam int unsigned DEF_RING_TICKS = 120000;
    localparam int unsigned DEF_MAX_SNZ    = 3;

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter that holds at zero; expired is high while the count is zero.
module tick_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ringing sequencer: ring on match, snooze with limit, stop-hold, auto timeout.
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned SNZ_TICKS  = DEF_SNZ_TICKS,
    parameter int unsigned STOP_TICKS = DEF_STOP_TICKS,
    parameter int unsigned RING_TICKS = DEF_RING_TICKS,
    parameter int unsigned MAX_SNZ    = DEF_MAX_SNZ
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic                         AlarmArmed,
    input  logic                         SetMode,
    input  logic                         Match,
    input  logic                         SnoozeBtn,
    input  logic                         StopBtn,
    output logic                         Buzzer,
    output logic                         Snoozing,
    output logic [$clog2(MAX_SNZ+1)-1:0] SnzCount,
    output logic                         Missed,
    output logic                         Done
);

    localparam int unsigned RW = $clog2(RING_TICKS + 1);
    localparam int unsigned SW = $clog2(SNZ_TICKS + 1);
    localparam int unsigned HW = $clog2(STOP_TICKS + 1);
    localparam int unsigned CW = $clog2(MAX_SNZ + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(STOP_TICKS - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_SNZ);

    ring_state_t   state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [CW-1:0] snz_cnt_q, snz_cnt_d;
    logic          snz_btn_q;
    logic          missed_q, missed_d;
    logic          done_q, done_d;
    logic          buzzer_q, buzzer_d;
    logic          snoozing_q, snoozing_d;
    logic          ring_load, snz_load;
    logic          ring_exp, snz_exp;
    logic          snz_edge, stop_done;

    tick_timer #(.WIDTH(RW)) u_ring_timer (
        .Clk      (Clk),
        .Rst      (Rst),
        .load     (ring_load),
        .load_val (RW'(RING_TICKS)),
        .en       (state_q == RING),
        .expired  (ring_exp)
    );

    tick_timer #(.WIDTH(SW)) u_snz_timer (
        .Clk      (Clk),
        .Rst      (Rst),
        .load     (snz_load),
        .load_val (SW'(SNZ_TICKS)),
        .en       (state_q == SNOOZE),
        .expired  (snz_exp)
    );

    assign snz_edge  = SnoozeBtn & ~snz_btn_q;
    assign stop_done = StopBtn && (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        hold_d    = '0;
        snz_cnt_d = snz_cnt_q;
        missed_d  = missed_q;
        done_d    = 1'b0;
        ring_load = 1'b0;
        snz_load  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Match && AlarmArmed && !SetMode) begin
                    state_d   = RING;
                    snz_cnt_d = '0;
                    missed_d  = 1'b0;
                    ring_load = 1'b1;
                end
            end
            RING, SNOOZE: begin
                // Priority: disarm, stop-hold completion, timer expiry, snooze edge.
                if (!AlarmArmed) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (stop_done) begin
                    state_d  = IDLE;
                    done_d   = 1'b1;
                    missed_d = 1'b0;
                end else begin
                    hold_d = StopBtn ? hold_q + 1'b1 : '0;
                    if (state_q == RING) begin
                        if (ring_exp) begin
                            state_d  = IDLE;
                            done_d   = 1'b1;
                            missed_d = 1'b1;
                        end else if (snz_edge && (snz_cnt_q < CNT_MAX)) begin
                            state_d   = SNOOZE;
                            snz_cnt_d = snz_cnt_q + 1'b1;
                            snz_load  = 1'b1;
                        end
                    end else if (snz_exp) begin
                        state_d   = RING;
                        ring_load = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        buzzer_d   = (state_d == RING);
        snoozing_d = (state_d == SNOOZE);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            snz_cnt_q  <= '0;
            snz_btn_q  <= 1'b0;
            missed_q   <= 1'b0;
            done_q     <= 1'b0;
            buzzer_q   <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            snz_cnt_q  <= snz_cnt_d;
            snz_btn_q  <= SnoozeBtn;
            missed_q   <= missed_d;
            done_q     <= done_d;
            buzzer_q   <= buzzer_d;
            snoozing_q <= snoozing_d;
        end
    end

    assign Buzzer   = buzzer_q;
    assign Snoozing = snoozing_q;
    assign SnzCount = snz_cnt_q;
    assign Missed   = missed_q;
    assign Done     = done_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Scoreboard bench for alarm_ring_ctrl: a cycle-count reference model queues expected outputs.
module tb_alarm_ring_ctrl;

    localparam int unsigned SNZ_T  = 8;
    localparam int unsigned STOP_T = 4;
    localparam int unsigned RING_T = 20;
    localparam int unsigned MAX_S  = 2;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       AlarmArmed = 1'b0, SetMode = 1'b0, Match = 1'b0;
    logic       SnoozeBtn = 1'b0, StopBtn = 1'b0;
    logic       Buzzer, Snoozing, Missed, Done;
    logic [1:0] SnzCount;

    always #5 Clk = ~Clk;

    alarm_ring_ctrl #(
        .SNZ_TICKS  (SNZ_T),
        .STOP_TICKS (STOP_T),
        .RING_TICKS (RING_T),
        .MAX_SNZ    (MAX_S)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .AlarmArmed (AlarmArmed),
        .SetMode    (SetMode),
        .Match      (Match),
        .SnoozeBtn  (SnoozeBtn),
        .StopBtn    (StopBtn),
        .Buzzer     (Buzzer),
        .Snoozing   (Snoozing),
        .SnzCount   (SnzCount),
        .Missed     (Missed),
        .Done       (Done)
    );

    typedef struct packed {
        logic       buz;
        logic       snz;
        logic [1:0] cnt;
        logic       missed;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: an alarm event is "active", optionally "snoozed";
    // segments are measured by how many edges they have lasted.
    bit m_active, m_snoozed, m_prev_sb, m_missed;
    int m_cnt, m_ring_edges, m_snz_edges, m_hold;

    function automatic void model_clear();
        m_active = 0; m_snoozed = 0; m_prev_sb = 0; m_missed = 0;
        m_cnt = 0; m_ring_edges = 0; m_snz_edges = 0; m_hold = 0;
    endfunction

    function automatic exp_t model_step();
        exp_t e;
        bit   done = 0;
        bit   edge_seen = SnoozeBtn && !m_prev_sb;
        int   hold_next;
        m_prev_sb = SnoozeBtn;
        if (!m_active) begin
            if (Match && AlarmArmed && !SetMode) begin
                m_active = 1; m_snoozed = 0; m_cnt = 0; m_missed = 0;
                m_ring_edges = 0; m_hold = 0;
            end
        end else begin
            hold_next = StopBtn ? m_hold + 1 : 0;
            if (!AlarmArmed) begin
                m_active = 0; done = 1;
            end else if (hold_next == int'(STOP_T)) begin
                m_active = 0; done = 1; m_missed = 0;
            end else begin
                m_hold = hold_next;
                if (!m_snoozed) begin
                    if (m_ring_edges == int'(RING_T)) begin
                        m_active = 0; done = 1; m_missed = 1;
                    end else if (edge_seen && m_cnt < int'(MAX_S)) begin
                        m_snoozed = 1; m_cnt++; m_snz_edges = 0;
                    end else begin
                        m_ring_edges++;
                    end
                end else begin
                    if (m_snz_edges == int'(SNZ_T)) begin
                        m_snoozed = 0; m_ring_edges = 0;
                    end else begin
                        m_snz_edges++;
                    end
                end
            end
            if (!m_active) m_hold = 0;
        end
        e.buz    = m_active && !m_snoozed;
        e.snz    = m_active && m_snoozed;
        e.cnt    = 2'(m_cnt);
        e.missed = m_missed;
        e.done   = done;
        return e;
    endfunction

    // Called at a negedge with inputs already set for the coming posedge.
    task automatic tick(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (Rst) begin
                model_clear();
                e = '0;
            end else begin
                e = model_step();
            end
            exp_q.push_back(e);
            @(negedge Clk);
        end
    endtask

    task automatic pulse_match();
        Match = 1'b1; tick(1); Match = 1'b0;
    endtask

    task automatic snooze_press();
        SnoozeBtn = 1'b1; tick(1); SnoozeBtn = 1'b0;
    endtask

    initial begin : monitor
        exp_t e, a;
        forever begin
            @(posedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {Buzzer, Snoozing, SnzCount, Missed, Done};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t got buz=%b snz=%b cnt=%0d missed=%b done=%b want buz=%b snz=%b cnt=%0d missed=%b done=%b",
                             $time, a.buz, a.snz, a.cnt, a.missed, a.done,
                             e.buz, e.snz, e.cnt, e.missed, e.done);
                end
            end
        end
    end

    initial begin : stimulus
        model_clear();
        tick(2);
        Rst = 1'b0;
        AlarmArmed = 1'b1;
        tick(2);

        // Unanswered alarm: ring times out, Missed set
        pulse_match();
        tick(25);

        // Snooze cycle, second snooze, ignored third edge, then interrupted stop hold
        pulse_match();
        tick(5);
        snooze_press();
        tick(12);
        snooze_press();
        tick(13);
        snooze_press();
        tick(4);
        StopBtn = 1'b1; tick(3);
        StopBtn = 1'b0; tick(1);
        StopBtn = 1'b1; tick(4);
        StopBtn = 1'b0; tick(3);

        // Stop-hold completion coincident with ring timeout
        pulse_match();
        tick(17);
        StopBtn = 1'b1; tick(4);
        StopBtn = 1'b0; tick(3);

        // Disarm during snooze
        pulse_match();
        snooze_press();
        tick(3);
        AlarmArmed = 1'b0; tick(1);
        tick(2);
        AlarmArmed = 1'b1; tick(1);

        // Match blocked by SetMode
        SetMode = 1'b1; pulse_match();
        SetMode = 1'b0; tick(3);

        // Reset while ringing clears outputs at once
        pulse_match();
        tick(3);
        Rst = 1'b1;
        #1;
        checks++;
        if ({Buzzer, Snoozing, SnzCount, Missed, Done} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset got buz=%b snz=%b cnt=%0d missed=%b done=%b want all 0",
                     Buzzer, Snoozing, SnzCount, Missed, Done);
        end
        tick(2);
        Rst = 1'b0;
        tick(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            AlarmArmed = ($urandom_range(0, 99) != 0);
            SetMode    = ($urandom_range(0, 9) == 0);
            Match      = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 5) == 0) SnoozeBtn = ~SnoozeBtn;
            if (StopBtn) begin
                if ($urandom_range(0, 3) == 0) StopBtn = 1'b0;
            end else if ($urandom_range(0, 6) == 0) begin
                StopBtn = 1'b1;
            end
            tick(1);
        end
        Match = 1'b0; SnoozeBtn = 1'b0; StopBtn = 1'b0;
        tick(2);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alarm_ring_ctrl.md
# alarm_ring_ctrl

Sequencer for the alarm-ringing phase of the alarm clock. It starts ringing on a time/alarm match, then handles snooze presses with a fixed snooze interval and a snooze limit. Holding stop for a set time ends the alarm, and an unanswered alarm times out on its own. It sits between the time/alarm comparator and the buzzer driver and runs on the same cycle count as the snooze/stop counters of the control circuit.

## Interface
- SNZ_TICKS, 60000: snooze interval in Clk cycles (1 minute at 1 kHz)
- STOP_TICKS, 1000: consecutive cycles StopBtn must be held to end the alarm
- RING_TICKS, 120000: ringing timeout in cycles before auto-stop
- MAX_SNZ, 3: snoozes allowed per alarm event
- Clk  input  1  system clock, rising edge
- Rst  input  1  asynchronous, active-high reset
- AlarmArmed  input  1  alarm enabled; low forces IDLE
- SetMode  input  1  user is editing alarm/time; blocks new alarm starts
- Match  input  1  one-cycle pulse: current time equals alarm time
- SnoozeBtn  input  1  snooze button level, synchronized upstream
- StopBtn  input  1  stop button level, synchronized upstream
- Buzzer  output  1  buzzer enable
- Snoozing  output  1  high while in the SNOOZE state
- SnzCount  output  $clog2(MAX_SNZ+1)  snoozes used in the current event
- Missed  output  1  sticky flag: the last alarm timed out unanswered
- Done  output  1  one-cycle pulse when an alarm event ends (stop, timeout or disarm)

## Operation
- States: IDLE, RING, SNOOZE. All outputs are registered.
- IDLE
  - Match & AlarmArmed & ~SetMode → RING.
  - On entry to RING: SnzCount=0, Missed=0, ring timer loaded with RING_TICKS.
- RING
  - Buzzer=1. The ring timer decrements each cycle.
  - Rising edge of SnoozeBtn with SnzCount<MAX_SNZ → SNOOZE: SnzCount+1, snooze timer loaded with SNZ_TICKS.
  - Snooze edge with SnzCount==MAX_SNZ is ignored.
  - Ring timer reaches 0 → IDLE, Missed=1, Done pulse.
- SNOOZE
  - Buzzer=0, Snoozing=1.
  - Snooze timer reaches 0 → RING with the ring timer reloaded. SnzCount is kept.
  - Snooze edges are ignored.
- Stop hold (active in RING and SNOOZE)
  - The hold counter increments while StopBtn=1 and clears to 0 when StopBtn=0.
  - Reaching STOP_TICKS → IDLE, Done pulse, Missed=0.
  - The hold counter always clears when entering IDLE.
- Snooze edge detection uses a registered copy of SnoozeBtn. A button already held when RING is entered does not produce an edge.
- Match outside IDLE is ignored (no restart, no reload).
- AlarmArmed=0 in RING or SNOOZE → IDLE on the next edge, Done pulse, Missed unchanged.
- Priority when events coincide in one cycle: disarm > stop-hold completion > ring/snooze timer expiry > snooze edge.
- SetMode has no effect outside IDLE.
- Timers are unsigned down-counters sized $clog2(max tick count + 1). They load the full tick count and expire on the cycle the value is 0. A timer is never decremented below 0.

## Timing
- Reset: state=IDLE, Buzzer=0, Snoozing=0, SnzCount=0, Missed=0, Done=0, all timers and hold counter 0, snooze-edge register 0.
- Match sampled at edge N → Buzzer=1 after edge N (1-cycle latency).
- Snooze edge sampled at edge N → Buzzer=0, Snoozing=1 after edge N.
- Ring duration: Buzzer is high for exactly RING_TICKS+1 cycles when unanswered.
- Snooze duration: Snoozing is high for exactly SNZ_TICKS+1 cycles.
- Stop: StopBtn high for STOP_TICKS consecutive sampled edges → IDLE on the STOP_TICKS-th edge.
- Done is high for exactly one cycle, coincident with the first IDLE cycle.
- Rst asserted mid-event clears everything immediately, with no Done pulse.

## Structure
- Shared package alarm_pkg
  - State enum ring_state_t {IDLE, RING, SNOOZE}.
  - Default tick constants for snooze, stop and ring.
- Sub-module tick_timer(load, load_val, en, expired), instanced twice: once as the ring timer, once as the snooze timer. The stop-hold counter is inline.

## Test plan
All scenarios use SNZ_TICKS=8, STOP_TICKS=4, RING_TICKS=20, MAX_SNZ=2.
- Unanswered alarm: Match pulse, no buttons → Buzzer high 21 cycles; then Missed=1, Done pulse, IDLE.
- Snooze cycle: snooze edge 5 cycles into RING → Snoozing 9 cycles, SnzCount=1, then Buzzer=1 again with full ring time.
- Snooze limit: two snoozes used, third edge → ignored, Buzzer stays 1, SnzCount=2.
- Stop hold: StopBtn high 3 cycles, low 1, high 4 → IDLE only after the second run; Missed=0, Done pulse.
- Coincident events: stop-hold completion on the same cycle as ring timeout → Missed=0. AlarmArmed dropped during SNOOZE → IDLE next cycle, Done pulse.
- Blocked start and reset: Match with SetMode=1 → stays IDLE. Rst asserted in RING → Buzzer=0 immediately, no Done pulse.
